// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph encodings
// (active-low {g,f,e,d,c,b,a}) and the digit index width.
package sevenseg_pkg;

  localparam int unsigned IDX_W = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational nibble-to-glyph decode. Codes 10..15 only light up in hex
// mode; otherwise they decode to a blank digit.
module seg_glyph_rom
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] seg
);

  // Glyph lookup, hex letters gated by hex_mode
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: if (hex_mode) seg = GLYPH_A;
      4'hB: if (hex_mode) seg = GLYPH_B;
      4'hC: if (hex_mode) seg = GLYPH_C;
      4'hD: if (hex_mode) seg = GLYPH_D;
      4'hE: if (hex_mode) seg = GLYPH_E;
      4'hF: if (hex_mode) seg = GLYPH_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. One digit is active
// per refresh slot; seg/dp/an are registered from the scan state, so they
// trail the counter/index/shadow registers by exactly one cycle.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  logic [CW-1:0]           cnt;
  logic                    tc;
  logic                    in_guard;
  logic [4*NUM_DIGITS-1:0] shadow_d;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [31:0]             word8;
  logic [7:0]              dp8;
  logic [7:0]              lz8;
  logic                    run;
  logic [3:0]              cur_nib;
  logic                    blank_digit;
  logic [6:0]              rom_seg;

  assign tc = (cnt == CW'(REFRESH_DIV - 1));

  generate
    if (GUARD_CYCLES > 0) begin : g_guard
      assign in_guard = (cnt < CW'(GUARD_CYCLES));
    end else begin : g_noguard
      assign in_guard = 1'b0;
    end
  endgenerate

  // Refresh counter, digit index and shadow capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      digit_idx <= '0;
      shadow_d  <= '0;
      shadow_dp <= '0;
    end else begin
      if (tc) begin
        cnt <= '0;
        if (digit_idx == IDX_W'(NUM_DIGITS - 1)) digit_idx <= '0;
        else                                     digit_idx <= digit_idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (load) begin
        shadow_d  <= digits_in;
        shadow_dp <= dp_in;
      end
    end
  end

  // Pad the shadow state to eight digits so the mux index never exceeds range
  assign word8   = 32'(shadow_d);
  assign dp8     = 8'(shadow_dp);
  assign cur_nib = word8[{digit_idx, 2'b00} +: 4];

  // lz8[k] set when nibbles k..7 are all zero (scanned from the top down)
  always_comb begin
    run = 1'b1;
    lz8 = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      run        = run & (word8[4*(7-i) +: 4] == 4'h0);
      lz8[7-i]   = run;
    end
  end

  assign blank_digit = blank_lz && (digit_idx != '0) && lz8[digit_idx];

  seg_glyph_rom u_rom (
    .nibble   (cur_nib),
    .hex_mode (hex_mode),
    .seg      (rom_seg)
  );

  // Registered display outputs; only one anode can ever be low
  always_ff @(posedge clk) begin
    if (rst || !enable || in_guard) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= blank_digit ? SEG_BLANK : rom_seg;
      dp  <= ~dp8[digit_idx];
      an  <= ~(NUM_DIGITS'(1) << digit_idx);
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: two instances (no guard / one guard cycle)
// run in lockstep against a time-based reference model.
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        hex_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic        enable = 1'b1;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] an0, an1;
  logic [2:0] idx0, idx1;

  int checks = 0;
  int failures = 0;

  // model state: cycles since reset release, shadow contents
  int          m_n = 0;
  logic [15:0] m_sh = '0;
  logic [3:0]  m_dp = '0;
  logic [14:0] e0, e1;
  logic [14:0] o0, o1;

  assign o0 = {an0, seg0, dp0, idx0};
  assign o1 = {an1, seg1, dp1, idx1};

  always #5 clk = ~clk;

  sevenseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .enable(enable),
    .seg(seg0), .dp(dp0), .an(an0), .digit_idx(idx0));

  sevenseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .enable(enable),
    .seg(seg1), .dp(dp1), .an(an1), .digit_idx(idx1));

  function automatic logic [6:0] glyph(input logic [3:0] v, input logic hex);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
          7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    if (!hex && v > 4'd9) return 7'h7F;
    return t[v];
  endfunction

  // Expected {an,seg,dp} one cycle after a state with n cycles elapsed
  function automatic logic [11:0] model_out(input int g, input int n, input logic [15:0] sh,
                                            input logic [3:0] dpm, input logic hex,
                                            input logic blz, input logic en);
    int idx, pos;
    logic [3:0] nib;
    logic blank;
    pos = n % 4;
    idx = (n / 4) % 4;
    if (!en || pos < g) return {4'hF, 7'h7F, 1'b1};
    nib   = 4'(sh >> (4 * idx));
    blank = blz && idx != 0 && ((sh >> (4 * idx)) == 16'h0);
    return {~(4'b0001 << idx), blank ? 7'h7F : glyph(nib, hex), ~dpm[idx]};
  endfunction

  task automatic step();
    logic [11:0] a0, a1;
    if (rst) begin
      a0 = {4'hF, 7'h7F, 1'b1};
      a1 = a0;
    end else begin
      a0 = model_out(0, m_n, m_sh, m_dp, hex_mode, blank_lz, enable);
      a1 = model_out(1, m_n, m_sh, m_dp, hex_mode, blank_lz, enable);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_n = 0; m_sh = '0; m_dp = '0;
    end else begin
      m_n++;
      if (load) begin m_sh = digits_in; m_dp = dp_in; end
    end
    e0 = {a0, 3'((m_n / 4) % 4)};
    e1 = {a1, 3'((m_n / 4) % 4)};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (o0 !== 15'b1111_1111111_1_000) begin
      failures++;
      $display("FAIL reset_g0 got=%b want=%b", o0, 15'b1111_1111111_1_000);
    end
    checks++;
    if (o1 !== 15'b1111_1111111_1_000) begin
      failures++;
      $display("FAIL reset_g1 got=%b want=%b", o1, 15'b1111_1111111_1_000);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    step();
    checks++;
    if (an0 !== 4'b1110 || seg0 !== 7'b1000000) begin
      failures++;
      $display("FAIL scan_first got an=%b seg=%b want an=1110 seg=1000000", an0, seg0);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (o0 !== e0) begin failures++; $display("FAIL scan_g0 cyc=%0d got=%b want=%b", i, o0, e0); end
      checks++;
      if (o1 !== e1) begin failures++; $display("FAIL scan_g1 cyc=%0d got=%b want=%b", i, o1, e1); end
    end
  endtask

  task automatic test_bcd();
    bit saw_d3;
    saw_d3 = 0;
    digits_in = 16'h1234; hex_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (o0 !== e0) begin failures++; $display("FAIL bcd_g0 cyc=%0d got=%b want=%b", i, o0, e0); end
      checks++;
      if (o1 !== e1) begin failures++; $display("FAIL bcd_g1 cyc=%0d got=%b want=%b", i, o1, e1); end
      if (an0 == 4'b0111) saw_d3 = 1;
    end
    checks++;
    if (!saw_d3) begin failures++; $display("FAIL bcd_digit3 got=not_seen want=an_0111"); end
  endtask

  task automatic test_lz();
    digits_in = 16'h00A5; blank_lz = 1'b1; hex_mode = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) hex_mode = 1'b0;
      step();
      checks++;
      if (o0 !== e0) begin failures++; $display("FAIL lz_g0 cyc=%0d got=%b want=%b", i, o0, e0); end
      checks++;
      if (o1 !== e1) begin failures++; $display("FAIL lz_g1 cyc=%0d got=%b want=%b", i, o1, e1); end
    end
  endtask

  task automatic test_dp();
    digits_in = 16'h0000; dp_in = 4'b0100; blank_lz = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (o0 !== e0) begin failures++; $display("FAIL dp_g0 cyc=%0d got=%b want=%b", i, o0, e0); end
      checks++;
      if ((dp0 == 1'b0) !== (an0 == 4'b1011)) begin
        failures++; $display("FAIL dp_slot got dp=%b an=%b want dp low only on an=1011", dp0, an0);
      end
    end
    dp_in = 4'b0000;
  endtask

  task automatic test_enable();
    digits_in = 16'h9876; blank_lz = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (o0 !== e0) begin failures++; $display("FAIL en_g0 cyc=%0d got=%b want=%b", i, o0, e0); end
      checks++;
      if (o1 !== e1) begin failures++; $display("FAIL en_g1 cyc=%0d got=%b want=%b", i, o1, e1); end
    end
    enable = 1'b1;
  endtask

  task automatic test_rst_mid();
    digits_in = 16'h5678; load = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (o0 !== 15'b1111_1111111_1_000) begin
      failures++; $display("FAIL rst_mid got=%b want=%b", o0, 15'b1111_1111111_1_000);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (o0 !== e0) begin failures++; $display("FAIL rstmid_g0 cyc=%0d got=%b want=%b", i, o0, e0); end
      checks++;
      if (o1 !== e1) begin failures++; $display("FAIL rstmid_g1 cyc=%0d got=%b want=%b", i, o1, e1); end
    end
  endtask

  task automatic test_tc_load();
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 4 && (m_n % 4) != 3; w++) step();
      digits_in = 16'($urandom); hex_mode = 1'b1; load = 1'b1;
      step();
      load = 1'b0;
      step();
      checks++;
      if (o0 !== e0) begin failures++; $display("FAIL tcload_g0 k=%0d got=%b want=%b", k, o0, e0); end
      checks++;
      if (o1 !== e1) begin failures++; $display("FAIL tcload_g1 k=%0d got=%b want=%b", k, o1, e1); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load      = ($urandom_range(0, 5) == 0);
      digits_in = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in     = 4'($urandom);
      hex_mode  = 1'($urandom);
      blank_lz  = 1'($urandom);
      enable    = ($urandom_range(0, 7) != 0);
      rst       = ($urandom_range(0, 60) == 0);
      step();
      checks++;
      if (o0 !== e0) begin failures++; $display("FAIL rand_g0 cyc=%0d got=%b want=%b", i, o0, e0); end
      checks++;
      if (o1 !== e1) begin failures++; $display("FAIL rand_g1 cyc=%0d got=%b want=%b", i, o1, e1); end
    end
    rst = 1'b0; load = 1'b0; enable = 1'b1;
  endtask

  initial begin
    #2;
    test_reset();
    test_scan();
    test_bcd();
    test_lz();
    test_dp();
    test_enable();
    test_rst_mid();
    test_tc_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
